// File: rtl/memctrl.sv
// Byte-serial memory responder: runs one CPU load/store/fetch as 1, 2 or 4 sequential
// byte accesses on a synchronous byte-wide RAM port, then pulses ready for one cycle.
module memctrl #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              we,
   input  logic [2:0]        cmd,
   input  logic [31:0]       ad,
   input  logic [31:0]       wd,
   output logic [31:0]       rd,
   output logic              ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              mem_we,
   output logic              mem_re
);

   localparam int unsigned CntW = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        last_q, last_d;
   logic [1:0]        k_q, k_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wd_q, wd_d;
   logic [31:0]       rd_q, rd_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic unused_bits;
   assign unused_bits = ^{cmd[2], ad[31:ADDR_W]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         last_q  <= 2'd0;
         k_q     <= 2'd0;
         addr_q  <= '0;
         wd_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         last_q  <= last_d;
         k_q     <= k_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
      end
   end

   // Strobes are decoded from state so an async reset drops them without a clock.
   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      last_d    = last_q;
      k_d       = k_q;
      addr_d    = addr_q;
      wd_d      = wd_q;
      rd_d      = rd_q;
      cnt_d     = cnt_q;
      ready     = 1'b0;
      mem_addr  = '0;
      mem_wdata = 8'h00;
      mem_we    = 1'b0;
      mem_re    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (en) begin
               we_d    = we;
               unique case (cmd[1:0])
                  2'd0:    last_d = 2'd0;
                  2'd1:    last_d = 2'd1;
                  default: last_d = 2'd3;
               endcase
               addr_d  = ad[ADDR_W-1:0];
               wd_d    = wd;
               rd_d    = '0;
               k_d     = 2'd0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            mem_addr = addr_q + ADDR_W'(k_q);
            if (we_q) begin
               mem_we    = 1'b1;
               mem_wdata = wd_q[8*k_q +: 8];
               if (k_q == last_q) begin
                  state_d = StDone;
               end else begin
                  k_d = k_q + 2'd1;
               end
            end else begin
               mem_re  = 1'b1;
               cnt_d   = CntW'(RD_LAT);
               state_d = StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               rd_d[8*k_q +: 8] = mem_rdata;
               if (k_q == last_q) begin
                  state_d = StDone;
               end else begin
                  k_d     = k_q + 2'd1;
                  state_d = StIssue;
               end
            end
         end
         StDone: begin
            ready   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign rd = rd_q;

endmodule

// File: tb/tb_memctrl.sv
// Scoreboard bench for memctrl: two instances (RD_LAT=1 and RD_LAT=3), each with a
// byte RAM model; a monitor per instance checks ready timing, rd and every RAM write.
module tb_memctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en1 = 1'b0, en3 = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  cmd = 3'b000;
   logic [31:0] ad = '0, wd = '0;

   logic [31:0] rd1, rd3;
   logic        ready1, ready3;
   logic [15:0] mem_addr1, mem_addr3;
   logic [7:0]  mem_wdata1, mem_wdata3, mem_rdata1, mem_rdata3;
   logic        mem_we1, mem_we3, mem_re1, mem_re3;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   int          exp_cyc1[$], exp_cyc3[$];
   logic [31:0] exp_rd1[$], exp_rd3[$];
   logic [23:0] exp_w1[$], exp_w3[$];

   logic [7:0] mem1 [0:65535];
   logic [7:0] mem3 [0:65535];
   logic [7:0] pipe1;
   logic [7:0] pipe3 [0:2];

   memctrl #(.ADDR_W(16), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .en(en1), .we(we), .cmd(cmd), .ad(ad), .wd(wd),
      .rd(rd1), .ready(ready1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1), .mem_we(mem_we1), .mem_re(mem_re1)
   );

   memctrl #(.ADDR_W(16), .RD_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .en(en3), .we(we), .cmd(cmd), .ad(ad), .wd(wd),
      .rd(rd3), .ready(ready3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
      .mem_rdata(mem_rdata3), .mem_we(mem_we3), .mem_re(mem_re3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM models: read data appears RD_LAT cycles after the read strobe.
   always @(posedge clk) begin
      if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
      pipe1 <= mem1[mem_addr1];
      if (mem_we3) mem3[mem_addr3] <= mem_wdata3;
      pipe3[0] <= mem3[mem_addr3];
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign mem_rdata1 = pipe1;
   assign mem_rdata3 = pipe3[2];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("no_overlap1", {63'b0, mem_we1 & mem_re1}, 64'd0);
         if (ready1) begin
            check("ready_pending1", {63'b0, exp_cyc1.size() != 0}, 64'd1);
            if (exp_cyc1.size() != 0) begin
               check("ready_cycle1", 64'(exp_cyc1.pop_front() - cyc), 64'd0);
               check("rd1", {32'b0, rd1}, {32'b0, exp_rd1.pop_front()});
            end
         end
         if (mem_we1) begin
            check("write_pending1", {63'b0, exp_w1.size() != 0}, 64'd1);
            if (exp_w1.size() != 0)
               check("write1", {40'b0, mem_addr1, mem_wdata1}, {40'b0, exp_w1.pop_front()});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("no_overlap3", {63'b0, mem_we3 & mem_re3}, 64'd0);
         if (ready3) begin
            check("ready_pending3", {63'b0, exp_cyc3.size() != 0}, 64'd1);
            if (exp_cyc3.size() != 0) begin
               check("ready_cycle3", 64'(exp_cyc3.pop_front() - cyc), 64'd0);
               check("rd3", {32'b0, rd3}, {32'b0, exp_rd3.pop_front()});
            end
         end
         if (mem_we3) begin
            check("write_pending3", {63'b0, exp_w3.size() != 0}, 64'd1);
            if (exp_w3.size() != 0)
               check("write3", {40'b0, mem_addr3, mem_wdata3}, {40'b0, exp_w3.pop_front()});
         end
      end
   end

   function automatic int nbytes(input logic [2:0] c);
      return (c[1:0] == 2'd0) ? 1 : (c[1:0] == 2'd1) ? 2 : 4;
   endfunction

   // Push expectations for one request starting this cycle (T0 = cyc).
   task automatic expect_req(input bit d3, input bit w, input logic [2:0] c,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] erd, input int t0);
      int n, lat;
      logic [15:0] wa;
      n   = nbytes(c);
      lat = w ? n + 1 : n * ((d3 ? 3 : 1) + 1) + 1;
      if (d3) begin
         exp_cyc3.push_back(t0 + lat);
         exp_rd3.push_back(erd);
      end else begin
         exp_cyc1.push_back(t0 + lat);
         exp_rd1.push_back(erd);
      end
      if (w) begin
         for (int k = 0; k < n; k++) begin
            wa = a[15:0] + 16'(k);
            if (d3) exp_w3.push_back({wa, d[8*k +: 8]});
            else    exp_w1.push_back({wa, d[8*k +: 8]});
         end
      end
   endtask

   task automatic req(input bit d3, input bit w, input logic [2:0] c, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] erd);
      int n, lat;
      @(posedge clk); #1;
      we = w; cmd = c; ad = a; wd = d;
      if (d3) en3 = 1'b1; else en1 = 1'b1;
      expect_req(d3, w, c, a, d, erd, cyc);
      n   = nbytes(c);
      lat = w ? n + 1 : n * ((d3 ? 3 : 1) + 1) + 1;
      @(posedge clk); #1;
      en1 = 1'b0; en3 = 1'b0;
      repeat (lat) @(posedge clk);
   endtask

   int t0;

   initial begin
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rd1", {32'b0, rd1}, 64'd0);
      check("rst_strobes1", {40'b0, mem_addr1, mem_wdata1, mem_we1, mem_re1, ready1}, 64'd0);
      check("rst_rd3", {32'b0, rd3}, 64'd0);
      check("rst_strobes3", {40'b0, mem_addr3, mem_wdata3, mem_we3, mem_re3, ready3}, 64'd0);
      rst = 1'b0;

      // Word store/load, rd holds after ready
      req(0, 1, 3'b010, 32'h10, 32'h44332211, 32'h0);
      req(0, 0, 3'b010, 32'h10, 32'h0, 32'h44332211);
      repeat (3) @(posedge clk);
      #1 check("rd_hold", {32'b0, rd1}, 64'h44332211);

      // Byte store leaves neighbours alone
      req(0, 1, 3'b010, 32'h20, 32'h99887766, 32'h0);
      req(0, 1, 3'b000, 32'h21, 32'hAABBCCDD, 32'h0);
      req(0, 0, 3'b010, 32'h20, 32'h0, 32'h9988DD66);

      // Unaligned halfword wrapping 0xFFFF -> 0x0000, upper address bits dropped
      req(0, 1, 3'b001, 32'h0000FFFF, 32'h00001234, 32'h0);
      req(0, 0, 3'b101, 32'h1234FFFF, 32'h0, 32'h00001234);

      // lb of 0x80 zero-extends; en toggling while busy is ignored
      req(0, 1, 3'b000, 32'h30, 32'h00000080, 32'h0);
      @(posedge clk); #1;
      en1 = 1'b1; we = 1'b0; cmd = 3'b000; ad = 32'h30;
      expect_req(0, 0, 3'b000, 32'h30, 32'h0, 32'h00000080, cyc);
      @(posedge clk); #1 en1 = 1'b1; we = 1'b1; ad = 32'h31; wd = 32'hFFFFFFFF;
      @(posedge clk); #1 en1 = 1'b0;
      @(posedge clk); #1 en1 = 1'b1;
      @(posedge clk); #1 en1 = 1'b0;
      repeat (2) @(posedge clk);

      // Reset during WAIT of a word load discards partial rd
      @(posedge clk); #1;
      en1 = 1'b1; we = 1'b0; cmd = 3'b010; ad = 32'h10;
      @(posedge clk); #1 en1 = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("partial_rd", {32'b0, rd1}, 64'h11);
      rst = 1'b1;
      #1;
      check("abort_rd", {32'b0, rd1}, 64'd0);
      check("abort_strobes", {61'b0, mem_we1, mem_re1, ready1}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      req(0, 0, 3'b010, 32'h10, 32'h0, 32'h44332211);

      // Reset during ISSUE of a store drops mem_we without a clock
      @(posedge clk); #1;
      en1 = 1'b1; we = 1'b1; cmd = 3'b010; ad = 32'h50; wd = 32'h12345678;
      exp_w1.push_back({16'h0050, 8'h78});
      @(posedge clk); #1 en1 = 1'b0;
      @(posedge clk); #1;
      check("store_we_before", {63'b0, mem_we1}, 64'd1);
      rst = 1'b1;
      #1 check("store_we_abort", {47'b0, mem_addr1, mem_we1}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      req(0, 0, 3'b100, 32'h50, 32'h0, 32'h00000078);

      // RD_LAT=3: lw then sw back to back with en held high
      req(1, 1, 3'b010, 32'h40, 32'hD4C3B2A1, 32'h0);
      @(posedge clk); #1;
      en3 = 1'b1; we = 1'b0; cmd = 3'b010; ad = 32'h40;
      t0 = cyc;
      expect_req(1, 0, 3'b010, 32'h40, 32'h0, 32'hD4C3B2A1, t0);
      expect_req(1, 1, 3'b010, 32'h44, 32'h0BADF00D, 32'h0, t0 + 18);
      @(posedge clk); #1;
      we = 1'b1; ad = 32'h44; wd = 32'h0BADF00D;
      repeat (18) @(posedge clk);
      #1 en3 = 1'b0;
      repeat (8) @(posedge clk);
      req(1, 0, 3'b010, 32'h44, 32'h0, 32'h0BADF00D);

      repeat (4) @(posedge clk);
      #1;
      check("left_ready1", 64'(exp_cyc1.size()), 64'd0);
      check("left_write1", 64'(exp_w1.size()), 64'd0);
      check("left_ready3", 64'(exp_cyc3.size()), 64'd0);
      check("left_write3", 64'(exp_w3.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
